// File: rtl/transfer_reg_n.sv
// transfer_reg_n: WIDTH-bit transfer register with A/B parallel load,
// synchronous clear and a counted shift sequence (logical or rotate left).
// Odd parity is accumulated over the bits shifted out of the MSB during a
// sequence, and TRS is the MSB delayed by one clock.
module transfer_reg_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             LD_A,
    input  logic             LD_B,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    input  logic             SHIFT_START,
    input  logic [CNT_W-1:0] SHIFT_N,
    input  logic             MODE,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             TRS,
    output logic             PAR,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trs_q;
    logic             par_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] shift_d;
    logic             msb;

    // Next-value candidates: wired-OR of the two memory paths, and one
    // left shift whose fill bit is either SIN or the outgoing MSB.
    always_comb begin
        msb     = q_q[WIDTH-1];
        load_d  = (LD_A ? DA : '0) | (LD_B ? DB : '0);
        shift_d = {q_q[WIDTH-2:0], (MODE ? msb : SIN)};
    end

    // Control FSM and datapath; priority RESET > CLR > load > shift > start.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            trs_q   <= 1'b0;
            par_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // TRS always follows the pre-edge MSB, even on clear or load.
            trs_q  <= msb;
            done_q <= 1'b0;
            if (CLR) begin
                q_q     <= '0;
                par_q   <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (LD_A || LD_B) begin
                // A load silently aborts any running sequence.
                q_q     <= load_d;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (state_q == S_SHIFT) begin
                q_q   <= shift_d;
                par_q <= par_q ^ msb;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (SHIFT_START) begin
                par_q <= 1'b1;
                if (SHIFT_N == '0) begin
                    // Zero-length sequence completes immediately.
                    done_q <= 1'b1;
                end else begin
                    cnt_q   <= SHIFT_N;
                    busy_q  <= 1'b1;
                    state_q <= S_SHIFT;
                end
            end
        end
    end

    assign Q    = q_q;
    assign SOUT = q_q[WIDTH-1];
    assign TRS  = trs_q;
    assign PAR  = par_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_transfer_reg_n.sv
// Bench for transfer_reg_n: directed vector table, a reset-abort sequence,
// then randomized traffic compared every cycle against a behavioural model.
module tb_transfer_reg_n;

    localparam int W  = 4;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RESET, CLR, LD_A, LD_B, SHIFT_START, MODE, SIN;
    logic [W-1:0]  DA, DB;
    logic [CW-1:0] SHIFT_N;
    logic [W-1:0]  Q;
    logic          SOUT, TRS, PAR, BUSY, DONE;

    int checks   = 0;
    int failures = 0;

    transfer_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .LD_A(LD_A), .LD_B(LD_B),
        .DA(DA), .DB(DB), .SHIFT_START(SHIFT_START), .SHIFT_N(SHIFT_N),
        .MODE(MODE), .SIN(SIN), .Q(Q), .SOUT(SOUT), .TRS(TRS), .PAR(PAR),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: register value plus the number of shifts still owed.
    logic [W-1:0] m_q;
    int           m_left;
    logic         m_par, m_trs, m_done;

    task automatic model_step();
        logic outb;
        if (RESET) begin
            m_q = '0; m_left = 0; m_par = 1'b1; m_trs = 1'b0; m_done = 1'b0;
        end else begin
            m_trs  = m_q[W-1];
            m_done = 1'b0;
            if (CLR) begin
                m_q = '0; m_par = 1'b1; m_left = 0;
            end else if (LD_A || LD_B) begin
                m_q = (LD_A ? DA : '0) | (LD_B ? DB : '0);
                m_left = 0;
            end else if (m_left > 0) begin
                outb   = m_q[W-1];
                m_q    = W'((m_q * 2) % (1 << W)) | W'(MODE ? outb : SIN);
                m_par  = m_par ^ outb;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (SHIFT_START) begin
                m_par = 1'b1;
                if (SHIFT_N == 0) m_done = 1'b1;
                else m_left = int'(SHIFT_N);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] eq,
                       input logic eb, input logic ed, input logic ep, input logic et);
        checks++;
        if (Q !== eq || SOUT !== eq[W-1] || BUSY !== eb || DONE !== ed ||
            PAR !== ep || TRS !== et) begin
            failures++;
            $display("FAIL %s: got Q=%b SOUT=%b BUSY=%b DONE=%b PAR=%b TRS=%b, want Q=%b SOUT=%b BUSY=%b DONE=%b PAR=%b TRS=%b",
                     name, Q, SOUT, BUSY, DONE, PAR, TRS, eq, eq[W-1], eb, ed, ep, et);
        end
    endtask

    typedef struct {
        logic          clr, lda, ldb;
        logic [W-1:0]  da, db;
        logic          start;
        logic [CW-1:0] n;
        logic          mode, sin;
        logic [W-1:0]  eq;
        logic          eb, ed, ep, et;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic clr, logic lda, logic ldb, logic [W-1:0] da,
                                logic [W-1:0] db, logic start, logic [CW-1:0] n,
                                logic mode, logic sin, logic [W-1:0] eq,
                                logic eb, logic ed, logic ep, logic et);
        vec_t v;
        v.clr = clr; v.lda = lda; v.ldb = ldb; v.da = da; v.db = db;
        v.start = start; v.n = n; v.mode = mode; v.sin = sin;
        v.eq = eq; v.eb = eb; v.ed = ed; v.ep = ep; v.et = et;
        return v;
    endfunction

    initial begin
        RESET = 1'b1; CLR = 0; LD_A = 0; LD_B = 0; DA = '0; DB = '0;
        SHIFT_START = 0; SHIFT_N = '0; MODE = 0; SIN = 0;

        //           clr lda ldb da       db       st n   md sin  Q        B  D  P  T
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0, 1, 0)); // idle after reset
        vt.push_back(mk(0, 1, 0, 4'b1011, 4'b0000, 0, 0,  0, 0, 4'b1011, 0, 0, 1, 0)); // load A
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b1011, 0, 0, 1, 1)); // TRS late
        vt.push_back(mk(0, 1, 1, 4'b1001, 4'b0110, 0, 0,  0, 0, 4'b1111, 0, 0, 1, 1)); // wired OR
        vt.push_back(mk(0, 1, 0, 4'b1011, 4'b0000, 0, 0,  0, 0, 4'b1011, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 3,  0, 0, 4'b1011, 1, 0, 1, 1)); // start N=3 logical
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b0110, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b1100, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b1000, 0, 1, 1, 1)); // done
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 2,  1, 0, 4'b1000, 1, 0, 1, 1)); // back-to-back rotate
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0001, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0010, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 4'b0000, 4'b0001, 0, 0,  1, 0, 4'b0001, 0, 0, 0, 0)); // load keeps PAR
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 5,  1, 0, 4'b0001, 1, 0, 1, 0)); // rotate 5 wraps
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0010, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0100, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b1000, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0001, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0010, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 0,  1, 0, 4'b0010, 0, 1, 1, 0)); // N=0
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0010, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 3,  1, 0, 4'b0010, 1, 0, 1, 0)); // start N=3
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 9,  1, 0, 4'b0100, 1, 0, 1, 0)); // start ignored
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b1000, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  1, 0, 4'b0001, 0, 1, 0, 1)); // still 3 long
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 4,  0, 1, 4'b0001, 1, 0, 1, 0)); // N=4, SIN=1
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 4'b0011, 1, 0, 1, 0));
        vt.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 4'b0000, 0, 0, 1, 0)); // CLR abort
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 4'b0000, 0, 0, 1, 0)); // no DONE
        vt.push_back(mk(0, 1, 0, 4'b1100, 4'b0000, 0, 0,  0, 0, 4'b1100, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 4,  0, 0, 4'b1100, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b1000, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 1, 4'b0000, 4'b0101, 0, 0,  0, 0, 4'b0101, 0, 0, 0, 1)); // LD_B abort
        vt.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 4'b0101, 0, 0, 0, 0)); // no DONE

        tick();
        tick();
        chk("reset_state", 4'b0000, 0, 0, 1, 0);
        RESET = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            CLR = vt[i].clr; LD_A = vt[i].lda; LD_B = vt[i].ldb;
            DA = vt[i].da; DB = vt[i].db; SHIFT_START = vt[i].start;
            SHIFT_N = vt[i].n; MODE = vt[i].mode; SIN = vt[i].sin;
            tick();
            chk($sformatf("vec%0d", i), vt[i].eq, vt[i].eb, vt[i].ed, vt[i].ep, vt[i].et);
        end

        // Reset in the middle of a 4-shift sequence.
        CLR = 0; LD_A = 0; LD_B = 0;
        LD_A = 1; DA = 4'b1010; tick(); LD_A = 0;
        chk("rst_seq_load", 4'b1010, 0, 0, 0, 0);
        SHIFT_START = 1; SHIFT_N = 5'd4; MODE = 1; tick(); SHIFT_START = 0;
        chk("rst_seq_start", 4'b1010, 1, 0, 1, 1);
        tick();
        chk("rst_seq_shift1", 4'b0101, 1, 0, 0, 1);
        RESET = 1; tick(); RESET = 0;
        chk("rst_seq_abort", 4'b0000, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst_seq_quiet%0d", i), 4'b0000, 0, 0, 1, 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            RESET       = ($urandom_range(0, 99) == 0);
            CLR         = ($urandom_range(0, 39) == 0);
            LD_A        = ($urandom_range(0, 19) == 0);
            LD_B        = ($urandom_range(0, 19) == 0);
            DA          = W'($urandom);
            DB          = W'($urandom);
            SHIFT_START = ($urandom_range(0, 3) == 0);
            SHIFT_N     = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 9));
            MODE        = W'($urandom) == 0 ? 1'b0 : 1'($urandom);
            SIN         = 1'($urandom);
            tick();
            chk($sformatf("rand%0d", c), m_q, (m_left > 0), m_done, m_par, m_trs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/transfer_reg_n.md
# transfer_reg_n

Parametrised transfer register for the LVDC simulation. It is a WIDTH-bit register with parallel load from memory module A or B, synchronous clear, and a counted serial shift sequence in logical or rotate mode. During each shift sequence it accumulates odd parity over the shifted-out bits and keeps a one-cycle-delayed sign/MSB bit. It generalises the fixed four-bit transfer register slice and sits between the memory buffer outputs and the shift/parity logic.

## Interface
- WIDTH, 4, register width in bits (≥2)
- CNT_W, 5, width of the shift-count input (up to 2^CNT_W−1 shifts per sequence)

- CLK  input  1  single system clock; all state changes on its rising edge
- RESET  input  1  synchronous, active-high reset
- CLR  input  1  clear register (CLTR function)
- LD_A  input  1  parallel load strobe, memory A path
- LD_B  input  1  parallel load strobe, memory B path
- DA  input  WIDTH  memory A data
- DB  input  WIDTH  memory B data
- SHIFT_START  input  1  start a shift sequence (sampled only when idle)
- SHIFT_N  input  CNT_W  number of shifts, sampled with SHIFT_START
- MODE  input  1  0 = logical shift left with SIN into LSB; 1 = rotate left
- SIN  input  1  serial input bit (next-lower stage output)
- Q  output  WIDTH  register contents
- SOUT  output  1  combinational Q[WIDTH-1]
- TRS  output  1  Q[WIDTH-1] registered one cycle late
- PAR  output  1  odd-parity accumulator over bits shifted out in the current or last sequence
- BUSY  output  1  shift sequence in progress
- DONE  output  1  one-cycle pulse when a sequence completes

## Operation
- States: IDLE, SHIFT. Down-counter CNT (CNT_W bits).
- Per-edge priority: RESET > CLR > load (LD_A/LD_B) > shift step > SHIFT_START.
- RESET: Q=0, TRS=0, PAR=1, BUSY=0, DONE=0, CNT=0, state IDLE.
- CLR: Q=0, PAR=1, state IDLE, BUSY=0. Aborts any sequence; no DONE.
- Load: Q ← (LD_A ? DA : 0) | (LD_B ? DB : 0). Both strobes together give a bitwise OR, matching wired-OR memory paths. A load during SHIFT aborts the sequence (IDLE, BUSY=0, no DONE). PAR is unchanged.
- SHIFT_START in IDLE with no CLR or load:
  - SHIFT_N=0: DONE=1 on the same edge; Q unchanged; BUSY stays 0; PAR=1.
  - SHIFT_N>0: CNT=SHIFT_N, PAR=1, BUSY=1, enter SHIFT. No shift on this edge.
- SHIFT_START while BUSY is ignored.
- Shift step (SHIFT state):
  - Q ← {Q[WIDTH-2:0], MODE ? Q[WIDTH-1] : SIN}.
  - PAR ← PAR ^ Q[WIDTH-1], using the bit shifted out.
  - CNT ← CNT−1. When CNT==1 before the step: go to IDLE, BUSY=0, DONE=1.
- DONE is 0 on every edge that does not complete a sequence.
- TRS ← Q[WIDTH-1] on every edge except RESET, including during CLR and loads. It uses the pre-edge Q value.
- Rotate by N ≥ WIDTH wraps naturally (N mod WIDTH net rotation); parity still counts all N shifted-out bits.

## Timing
- SHIFT_START sampled at edge k with N>0: shifts occur at edges k+1 … k+N. BUSY is high from k to k+N; DONE is high for the one cycle after edge k+N; Q and PAR are final at the same edge.
- N=0: DONE is high for the one cycle after edge k.
- Back-to-back: a new SHIFT_START is accepted on the edge after DONE rises, since BUSY is already 0.
- Load and CLR take effect at the edge where they are sampled (latency 1). SOUT is combinational from Q.

## Test plan
- Reset, then hold idle -> Q=0000, TRS=0, PAR=1, BUSY=0, DONE=0.
- LD_A, DA=1011 -> Q=1011. Then LD_A+LD_B with DA=1001, DB=0110 -> Q=1111. TRS=1 one cycle after Q[3]=1.
- Q=1011, MODE=0, SIN=0, SHIFT_N=3 -> Q goes 0110, 1100, 1000; BUSY high for 3 cycles; DONE pulses with Q=1000; PAR=1.
- Q=1000, MODE=1, SHIFT_N=2 -> Q goes 0001, 0010; PAR=0. Then SHIFT_N=5 from Q=0001 -> Q=0010 (wrap).
- SHIFT_N=0 -> DONE pulse after 1 edge, Q unchanged, BUSY never high. SHIFT_START pulsed mid-sequence -> ignored, and sequence length is unchanged.
- SHIFT_N=4 aborted by CLR at the 2nd shift -> Q=0000, BUSY=0, no DONE, PAR=1. Repeat with RESET, then with LD_B (DB=0101) -> Q=0101, no DONE.
